// File: rtl/cnn_layer_accel_awe_accum_if.sv
// Bundles the configuration, partial-sum input and result-output signals of
// the AWE accumulator. master = producer/consumer side, slave = accumulator.
// Ports: new_map/num_passes/row_len (config), datain_* (sums in),
//        dataout_* (results out), busy/map_done/overflow (status).
interface cnn_layer_accel_awe_accum_if #(
  parameter int P_W    = 48,
  parameter int PASS_W = 8,
  parameter int ROW_W  = 7
);
  logic              new_map;
  logic [PASS_W-1:0] num_passes;
  logic [ROW_W-1:0]  row_len;
  logic              datain_valid;
  logic [P_W-1:0]    datain_p;
  logic              dataout_valid;
  logic              dataout_ready;
  logic [P_W-1:0]    dataout;
  logic              busy;
  logic              map_done;
  logic              overflow;

  modport master (
    output new_map, num_passes, row_len, datain_valid, datain_p, dataout_ready,
    input  dataout_valid, dataout, busy, map_done, overflow
  );

  modport slave (
    input  new_map, num_passes, row_len, datain_valid, datain_p, dataout_ready,
    output dataout_valid, dataout, busy, map_done, overflow
  );
endinterface

// File: rtl/cnn_layer_accel_awe_accum.sv
// Multi-pass accumulator for AWE partial sums; the final pass feeds a FWFT output FIFO.
// Latency: final-pass input to dataout_valid is 1 cycle (empty FIFO); map_done 1 cycle after last push.
// Backpressure: none on datain; a result arriving at a full FIFO with no pop is dropped and sets overflow.
// Ports: clk, rst (sync, active-high); bus (slave modport): config, datain, dataout, status.
module cnn_layer_accel_awe_accum #(
  parameter int C_P_OUTPUT_WIDTH = 48,
  parameter int C_ROW_LEN        = 64,
  parameter int C_OUT_FIFO_DEPTH = 16,
  parameter int C_PASS_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst,
  cnn_layer_accel_awe_accum_if.slave bus
);
  localparam int P_W    = C_P_OUTPUT_WIDTH;
  localparam int PASS_W = C_PASS_WIDTH;
  localparam int ROW_W  = $clog2(C_ROW_LEN) + 1;
  localparam int ADDR_W = (C_ROW_LEN > 1) ? $clog2(C_ROW_LEN) : 1;
  localparam int FA_W   = $clog2(C_OUT_FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;

  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] pass_cnt;
  logic [ROW_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr;
  logic              map_done_q;
  logic              overflow_q;
  logic [P_W-1:0]    buffer [C_ROW_LEN];

  // Configuration sanitising: zero passes means one; out-of-range lengths mean full row.
  logic [PASS_W-1:0] np_eff;
  logic [ROW_W-1:0]  rl_eff;
  assign np_eff = (bus.num_passes == '0) ? PASS_W'(1) : bus.num_passes;
  assign rl_eff = ((bus.row_len == '0) || (bus.row_len > ROW_W'(C_ROW_LEN)))
                  ? ROW_W'(C_ROW_LEN) : bus.row_len;

  logic start, accept, first_pass, last_pass, last_entry, final_in;
  logic [P_W-1:0] buf_rd, sum, push_dat;
  logic push_req, push_ok;

  assign start      = (state == IDLE) && bus.new_map;
  assign accept     = (state == ACCUM) && bus.datain_valid;
  assign first_pass = (pass_cnt == '0);
  assign last_pass  = (pass_cnt == passes_q - PASS_W'(1));
  assign last_entry = (ROW_W'(addr) == len_q - ROW_W'(1));
  assign final_in   = accept && last_pass && last_entry;

  // Asynchronous buffer read keeps read-modify-write single-cycle, so
  // back-to-back hits on one address always see the previous update.
  assign buf_rd   = buffer[addr];
  assign sum      = buf_rd + bus.datain_p;
  // With a single pass the buffer was never written for this map.
  assign push_dat = (passes_q == PASS_W'(1)) ? bus.datain_p : sum;
  assign push_req = accept && last_pass;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (final_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencing and status
  always_ff @(posedge clk) begin
    if (rst) begin
      passes_q   <= PASS_W'(1);
      len_q      <= ROW_W'(C_ROW_LEN);
      addr       <= '0;
      pass_cnt   <= '0;
      map_done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      map_done_q <= final_in;
      if (start) begin
        passes_q   <= np_eff;
        len_q      <= rl_eff;
        addr       <= '0;
        pass_cnt   <= '0;
        overflow_q <= 1'b0;
      end else if (accept) begin
        if (last_entry) begin
          addr     <= '0;
          pass_cnt <= pass_cnt + PASS_W'(1);
        end else begin
          addr <= addr + ADDR_W'(1);
        end
        if (push_req && !push_ok) overflow_q <= 1'b1;
      end
    end
  end

  // Partial-sum buffer: pass 0 overwrites, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept && !last_pass) buffer[addr] <= first_pass ? bus.datain_p : sum;
  end

  // First-word-fall-through output FIFO (extra pointer bit distinguishes full/empty)
  logic [P_W-1:0]  fifo_mem [C_OUT_FIFO_DEPTH];
  logic [FA_W:0]   wr_ptr, rd_ptr;
  logic            fifo_empty, fifo_full, out_vld, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FA_W] != rd_ptr[FA_W]) &&
                      (wr_ptr[FA_W-1:0] == rd_ptr[FA_W-1:0]);
  assign out_vld    = !rst && !fifo_empty;
  assign pop        = out_vld && bus.dataout_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (FA_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (FA_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr[FA_W-1:0]] <= push_dat;
  end

  assign bus.dataout_valid = out_vld;
  assign bus.dataout       = out_vld ? fifo_mem[rd_ptr[FA_W-1:0]] : '0;
  assign bus.busy          = (state == ACCUM);
  assign bus.map_done      = map_done_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_cnn_layer_accel_awe_accum.sv
// Directed bench for the AWE accumulator: inputs change 1 ns after the rising
// edge, a negedge monitor records popped words and map_done pulses, and each
// comparison is an immediate assertion against a hand-computed value.
module tb_cnn_layer_accel_awe_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_accel_awe_accum_if #(.P_W(48), .PASS_W(8), .ROW_W(7)) ifc ();

  cnn_layer_accel_awe_accum #(
    .C_P_OUTPUT_WIDTH(48), .C_ROW_LEN(64), .C_OUT_FIFO_DEPTH(16), .C_PASS_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int tests = 0;
  int fails = 0;
  logic [47:0] got[$];
  int md_cnt = 0;

  // A pop happens at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.dataout_valid && ifc.dataout_ready) got.push_back(ifc.dataout);
      if (ifc.map_done) md_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] np, input logic [6:0] rl);
    ifc.new_map = 1'b1;
    ifc.num_passes = np;
    ifc.row_len = rl;
    tick();
    ifc.new_map = 1'b0;
  endtask

  task automatic send(input logic [47:0] v);
    ifc.datain_valid = 1'b1;
    ifc.datain_p = v;
    tick();
    ifc.datain_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (ifc.dataout_valid && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("drain_bound", (n < 200), 1);
  endtask

  initial begin
    rst = 1'b1;
    ifc.new_map = 1'b0;
    ifc.num_passes = '0;
    ifc.row_len = '0;
    ifc.datain_valid = 1'b0;
    ifc.datain_p = '0;
    ifc.dataout_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", ifc.busy, 0);
    check("rst_valid", ifc.dataout_valid, 0);
    check("rst_dataout", ifc.dataout, 0);
    check("rst_map_done", ifc.map_done, 0);
    check("rst_overflow", ifc.overflow, 0);
    rst = 1'b0;
    tick();

    // One pass, four entries
    got.delete(); md_cnt = 0;
    start(1, 4);
    check("t1_busy", ifc.busy, 1);
    for (int i = 1; i <= 4; i++) send(48'(i));
    check("t1_map_done", ifc.map_done, 1);
    check("t1_busy_after", ifc.busy, 0);
    drain();
    check("t1_count", got.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_data", got[i], 64'(i + 1));
    check("t1_md_pulses", md_cnt, 1);

    // Data while idle is ignored
    got.delete(); md_cnt = 0;
    send(48'd99);
    tick();
    check("idle_no_out", got.size(), 0);
    check("idle_valid", ifc.dataout_valid, 0);

    // Three passes of two; a new_map mid-map must be ignored
    start(3, 2);
    send(10);
    start(1, 1);
    check("t2_busy_after_ignored_new_map", ifc.busy, 1);
    send(20); send(1); send(2);
    check("t2_no_early_out", got.size(), 0);
    check("t2_no_early_valid", ifc.dataout_valid, 0);
    send(100); send(200);
    drain();
    check("t2_count", got.size(), 2);
    check("t2_d0", got[0], 111);
    check("t2_d1", got[1], 222);

    // Overflow: 17 results into a 16-deep FIFO with no consumer
    got.delete(); md_cnt = 0;
    ifc.dataout_ready = 1'b0;
    start(1, 17);
    for (int i = 1; i <= 17; i++) send(48'(i));
    check("t3_overflow", ifc.overflow, 1);
    check("t3_valid", ifc.dataout_valid, 1);
    check("t3_head", ifc.dataout, 1);
    ifc.dataout_ready = 1'b1;
    drain();
    check("t3_count", got.size(), 16);
    for (int i = 0; i < 16; i++) check("t3_data", got[i], 64'(i + 1));
    check("t3_empty", ifc.dataout_valid, 0);
    check("t3_overflow_sticky", ifc.overflow, 1);

    // Modular wrap on back-to-back same-address accumulate
    got.delete(); md_cnt = 0;
    start(2, 1);
    check("t4_overflow_cleared", ifc.overflow, 0);
    send(48'hFFFF_FFFF_FFFF);
    send(2);
    drain();
    check("t4_count", got.size(), 1);
    check("t4_wrap", got[0], 1);

    // Zero configuration means one pass of the full 64-entry row
    got.delete(); md_cnt = 0;
    start(0, 0);
    for (int i = 0; i < 63; i++) send(48'(i + 1));
    check("t5_no_done_yet", md_cnt, 0);
    check("t5_busy", ifc.busy, 1);
    send(64);
    check("t5_map_done", ifc.map_done, 1);
    check("t5_idle", ifc.busy, 0);
    drain();
    check("t5_count", got.size(), 64);
    check("t5_last", got[63], 64);
    check("t5_no_overflow", ifc.overflow, 0);

    // Reset mid-map, then a clean map
    got.delete(); md_cnt = 0;
    start(3, 2);
    send(1); send(2); send(3);
    rst = 1'b1;
    tick();
    check("t6_rst_busy", ifc.busy, 0);
    check("t6_rst_valid", ifc.dataout_valid, 0);
    rst = 1'b0;
    tick();
    start(2, 2);
    send(5); send(6); send(7); send(8);
    drain();
    check("t6_count", got.size(), 2);
    check("t6_d0", got[0], 12);
    check("t6_d1", got[1], 14);
    check("t6_md_pulses", md_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cnn_layer_accel_awe_accum.md
CNN_LAYER_ACCEL_AWE_ACCUM -- requirements
Module: cnn_layer_accel_awe_accum

Interface
REQ-001 Parameter C_P_OUTPUT_WIDTH, default 48: width of the AWE DSP partial-sum word and of all accumulators.
REQ-002 Parameter C_ROW_LEN, default 64: maximum accumulation entries per pass.
REQ-003 Parameter C_OUT_FIFO_DEPTH, default 16: output FIFO depth in words, a power of 2.
REQ-004 Parameter C_PASS_WIDTH, default 8: width of the pass-count configuration.
REQ-005 Port clk, input, 1: single clock. Reset is synchronous and active-high.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port new_map, input, 1: one-cycle start pulse; latches num_passes and row_len.
REQ-008 Port num_passes, input, C_PASS_WIDTH: number of accumulation passes per map.
REQ-009 Port row_len, input, clog2(C_ROW_LEN)+1: entries per pass.
REQ-010 Port datain_valid, input, 1: partial sum valid; this is the AWE dataout_valid.
REQ-011 Port datain_p, input, C_P_OUTPUT_WIDTH: partial sum; this is the AWE dataout_p.
REQ-012 Port dataout_valid, output, 1: the output FIFO is non-empty.
REQ-013 Port dataout_ready, input, 1: consumer accepts dataout.
REQ-014 Port dataout, output, C_P_OUTPUT_WIDTH: final accumulated word at the FIFO head.
REQ-015 Port busy, output, 1: high while the block is in the ACCUM state.
REQ-016 Port map_done, output, 1: one-cycle pulse when the last result of a map is pushed.
REQ-017 Port overflow, output, 1: sticky flag indicating a result was dropped.

Function
REQ-018 The block SHALL implement two states, IDLE and ACCUM.
  - IDLE to ACCUM: on new_map.
  - ACCUM to IDLE: on the final entry of the final pass.
REQ-019 The block SHALL latch configuration on new_map in IDLE.
  - num_passes=0 SHALL be treated as 1.
  - row_len=0 or row_len>C_ROW_LEN SHALL be treated as C_ROW_LEN.
  - new_map also clears overflow, addr and pass_cnt.
REQ-020 The block SHALL ignore new_map while in ACCUM.
REQ-021 The block SHALL ignore datain_valid while in IDLE; no state changes.
REQ-022 The block SHALL handle each datain_valid in ACCUM at buffer[addr] as follows:
  - On pass 0, when it is not the final pass: write datain_p.
  - On middle passes: buffer[addr] += datain_p.
  - On the final pass: push (buffer[addr] + datain_p) to the FIFO, or datain_p alone if num_passes=1.
REQ-023 The block SHALL perform all additions unsigned, modulo 2^C_P_OUTPUT_WIDTH, with no saturation.
REQ-024 The block SHALL support read-modify-write at the same address on consecutive cycles (row_len=1) with no hazard.
  - Each accumulate SHALL complete in the cycle it is accepted.
REQ-025 The block SHALL wrap addr from row_len-1 to 0 and increment pass_cnt at the same time.
REQ-026 The block SHALL assert map_done for exactly one cycle, the cycle after the final push, and SHALL also return to IDLE then.
REQ-027 The output FIFO SHALL be first-word fall-through.
  - A pushed word appears on dataout with dataout_valid=1 the cycle after the push when the FIFO was empty.
  - A pop occurs when dataout_valid && dataout_ready.
REQ-028 The FIFO SHALL accept a push when it is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set to 1, and the accumulation sequence continues.
REQ-029 The FIFO SHALL keep its contents across new_map; they are drained only by pops or reset.
REQ-030 The block SHALL exert no backpressure on datain; it has no input ready signal.

Reset
REQ-031 On rst=1 the block SHALL go to IDLE and clear addr, pass_cnt and the FIFO pointers. Output values during reset:
  - dataout_valid=0, dataout=0, busy=0, map_done=0, overflow=0.
REQ-032 Reset mid-ACCUM SHALL abandon the map; after reset the block SHALL accept a new new_map with no residual effect.
REQ-033 Buffer contents need not be reset, because pass 0 always overwrites them.

Verification
REQ-034 num_passes=1, row_len=4, inputs 1,2,3,4 -> dataout 1,2,3,4 in order; one map_done pulse; busy low after.
REQ-035 num_passes=3, row_len=2, inputs 10,20,1,2,100,200 -> dataout 111,222; no output before the 5th input.
REQ-036 dataout_ready=0, num_passes=1, row_len=17, 17 inputs -> FIFO holds the first 16, overflow=1. Then ready=1 -> 16 pops in order, and dataout_valid=0 after them.
REQ-037 num_passes=2, row_len=1, inputs 2^48-1 then 2 on back-to-back cycles -> dataout 1.
REQ-038 num_passes=0, row_len=0 -> behaves as 1 pass of 64 entries; the 64th input produces map_done.
REQ-039 rst during pass 1 of a 3-pass map -> busy=0, dataout_valid=0. A fresh map num_passes=2, row_len=2, inputs 5,6,7,8 -> dataout 12,14.
